breath_controller: RTL and testbench
====================================

BREATH_CONTROLLER -- requirements
Module: breath_controller

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL have parameter DUTY_LIMIT, default 100, the absolute ceiling for io_duty in percent.
REQ-003 The block SHALL have parameter HOLD_STEPS, default 50, the number of step ticks spent at peak, with a legal range of 1..255.
REQ-004 Port `clock`: input, 1 bit, sole clock, rising edge.
REQ-005 Port `reset`: input, 1 bit, synchronous, active-high.
REQ-006 Port `io_enable`: input, 1 bit; high requests continuous breathing, low requests a ramp-down to idle.
REQ-007 Port `io_stepDiv`: input, 16 bits; clock cycles per step tick, minus one.
REQ-008 Port `io_dutyMax`: input, 7 bits; requested peak duty, sampled on every tick.
REQ-009 Port `io_duty`: output, 7 bits, registered; drives the downstream PWM generator's `io_duty` directly.
REQ-010 Port `io_phase`: output, 2 bits, registered; encodes the current state (0 IDLE, 1 RISE, 2 HOLD, 3 FALL).
REQ-011 Port `io_cycleDone`: output, 1 bit, registered; a one-cycle pulse at the end of each full breath.

Function
REQ-012 The prescaler SHALL be a 16-bit counter that asserts internal `tick` in any cycle where count == io_stepDiv, then wraps to 0 on the next edge.
REQ-013 io_stepDiv = 0 SHALL produce a tick every cycle.
REQ-014 If io_stepDiv is lowered below the current count, the counter SHALL wrap through 0xFFFF; no error is required.
REQ-015 The prescaler SHALL be held at 0 while in IDLE and SHALL start from 0 in the first non-IDLE cycle.
REQ-016 The effective peak SHALL be peak = min(io_dutyMax, DUTY_LIMIT), computed combinationally each cycle.
REQ-017 IDLE: io_duty = 0, and io_enable high SHALL move the state to RISE on the next edge.
REQ-018 RISE, on tick: if duty < peak then duty +1; else go to HOLD and clear the hold counter, with duty unchanged (no clamp when duty > peak).
REQ-019 HOLD, on tick: the hold counter SHALL increment; when hold counter == HOLD_STEPS-1, the state SHALL go to FALL.
REQ-020 FALL, on tick: if duty > 0 then duty -1; else pulse io_cycleDone and go to RISE if io_enable is high, otherwise to IDLE.
REQ-021 io_enable low while in RISE or HOLD SHALL force FALL on the next edge, regardless of tick, with duty unchanged.
REQ-022 io_enable high during FALL SHALL NOT abort the ramp; FALL SHALL complete to 0 first.
REQ-023 Between ticks, duty, state and the hold counter SHALL hold their values, except as required by REQ-021.
REQ-024 All updates SHALL take effect on the edge ending the tick cycle and be visible one cycle later, giving a latency of 1 cycle.
REQ-025 io_duty SHALL never exceed DUTY_LIMIT, never wrap below 0, and change by at most 1 per tick.
REQ-026 io_cycleDone SHALL be high for exactly one cycle, coincident with the first cycle of the following RISE or IDLE.
REQ-027 peak = 0 SHALL give RISE a direct transition to HOLD at duty 0 on the first tick.

Reset
REQ-028 While reset is high at a rising edge, the next state SHALL be: state IDLE, io_duty = 0, io_phase = 0, io_cycleDone = 0, prescaler = 0, hold counter = 0.
REQ-029 Reset asserted mid-operation SHALL return the block to IDLE on the next edge with no intermediate ramp-down, and reset SHALL take precedence over io_enable.
REQ-030 After reset deasserts with io_enable already high, the block SHALL enter RISE one cycle later.

Verification
REQ-031 Full breath: DUTY_LIMIT=100, HOLD_STEPS=2, io_stepDiv=0, io_dutyMax=3, io_enable rises at cycle 0 -> io_duty over cycles 1..11 = 0,1,2,3,3,3,3,2,1,0,0; io_phase = 1,1,1,1,2,2,3,3,3,3,1; io_cycleDone high only at cycle 11.
REQ-032 Prescaler: io_stepDiv=9, io_dutyMax=5 -> io_duty increments exactly every 10 cycles during RISE.
REQ-033 Saturation: io_dutyMax=127 -> io_duty stops at 100, HOLD is entered, and io_duty never exceeds 100.
REQ-034 Early stop: io_enable dropped at duty 40 in RISE -> io_phase = 3 on the next cycle; duty steps down from 40 to 0; io_cycleDone pulses; io_phase returns to 0 and stays there.
REQ-035 Reset mid-HOLD at duty 100 -> the next cycle shows io_duty = 0, io_phase = 0 and io_cycleDone = 0; with io_enable still high, io_phase = 1 one cycle after reset deasserts.
REQ-036 Live peak change: io_dutyMax lowered from 50 to 20 while duty = 30 in RISE -> on the next tick the state goes to HOLD with duty held at 30.

Source files
------------

// File: rtl/breath_controller.sv
// breath_controller: LED breathing envelope (rise, hold at peak, fall) stepped by a prescaler
module breath_controller #(
  parameter int DUTY_LIMIT = 100,
  parameter int HOLD_STEPS = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_enable,
  input  logic [15:0] io_stepDiv,
  input  logic [6:0]  io_dutyMax,
  output logic [6:0]  io_duty,
  output logic [1:0]  io_phase,
  output logic        io_cycleDone
);
  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} state_e;
  localparam int LIM_C = DUTY_LIMIT > 127 ? 127 : DUTY_LIMIT;
  localparam logic [6:0] LIM = 7'(LIM_C);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_STEPS - 1);
  state_e state_q, state_d;
  logic [6:0] duty_q, duty_d, peak;
  logic [7:0] hold_q, hold_d;
  logic [15:0] cnt_q, cnt_d;
  logic done_q, done_d, tick, at_peak, empty;
  assign peak = io_dutyMax > LIM ? LIM : io_dutyMax;
  assign tick = cnt_q == io_stepDiv;
  assign at_peak = duty_q >= peak;
  assign empty = duty_q == 7'd0;
  // state and datapath registers, reset wins over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // next state: enable low aborts rise/hold at once, a fall always runs to zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = io_enable ? RISE : IDLE;
      RISE: state_d = !io_enable ? FALL : (tick && at_peak) ? HOLD : RISE;
      HOLD: state_d = !io_enable ? FALL : (tick && hold_q == HOLD_LAST) ? FALL : HOLD;
      FALL: state_d = (tick && empty) ? (io_enable ? RISE : IDLE) : FALL;
    endcase
  end
  // next duty, hold count, prescaler and end-of-breath pulse
  always_comb begin
    cnt_d  = (state_q == IDLE || tick) ? 16'd0 : cnt_q + 16'd1;
    duty_d = (state_q == RISE && io_enable && tick && !at_peak) ? duty_q + 7'd1 :
             (state_q == FALL && tick && !empty) ? duty_q - 7'd1 : duty_q;
    hold_d = (state_q == RISE && io_enable && tick && at_peak) ? 8'd0 :
             (state_q == HOLD && io_enable && tick) ? hold_q + 8'd1 : hold_q;
    done_d = state_q == FALL && tick && empty;
  end
  assign io_duty = duty_q;
  assign io_phase = state_q;
  assign io_cycleDone = done_q;
endmodule

// File: tb/tb_breath_controller.sv
// tb_breath_controller: reference-model and directed checks of breath_controller
module tb_breath_controller;
  logic clock = 1'b0, reset = 1'b1, io_enable = 1'b0;
  logic [15:0] io_stepDiv = '0;
  logic [6:0] io_dutyMax = '0, io_duty;
  logic [1:0] io_phase;
  logic io_cycleDone;
  int tot = 0, pass = 0, cyc = 0, t1 = 0, t2 = 0;
  bit go = 0;
  int m_ph = 0, m_duty = 0, m_hold = 0, m_cnt = 0, m_done = 0, pk = 0;
  bit tk;
  int exp_duty [11] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0};
  int exp_ph [11] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 1};

  breath_controller #(.DUTY_LIMIT(100), .HOLD_STEPS(2)) dut (
    .clock(clock), .reset(reset), .io_enable(io_enable), .io_stepDiv(io_stepDiv),
    .io_dutyMax(io_dutyMax), .io_duty(io_duty), .io_phase(io_phase), .io_cycleDone(io_cycleDone)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // behavioural model: phase 0 idle, 1 rise, 2 hold, 3 fall
  always @(posedge clock) begin
    if (reset) begin
      m_ph = 0; m_duty = 0; m_hold = 0; m_cnt = 0; m_done = 0;
    end else begin
      pk = io_dutyMax < 100 ? int'(io_dutyMax) : 100;
      tk = m_ph != 0 && m_cnt == int'(io_stepDiv);
      m_cnt = (m_ph == 0 || tk) ? 0 : (m_cnt + 1) % 65536;
      m_done = 0;
      if (m_ph == 0) begin
        if (io_enable) m_ph = 1;
      end else if (m_ph == 1) begin
        if (!io_enable) m_ph = 3;
        else if (tk && m_duty < pk) m_duty++;
        else if (tk) begin m_ph = 2; m_hold = 0; end
      end else if (m_ph == 2) begin
        if (!io_enable) m_ph = 3;
        else if (tk) begin
          if (m_hold == 1) m_ph = 3;
          m_hold++;
        end
      end else if (tk) begin
        if (m_duty > 0) m_duty--;
        else begin m_done = 1; m_ph = io_enable ? 1 : 0; end
      end
    end
  end

  always @(negedge clock) if (go) begin
    chk("model_duty", int'(io_duty), m_duty);
    chk("model_phase", int'(io_phase), m_ph);
    chk("model_done", int'(io_cycleDone), m_done);
  end

  task automatic wait_idle(input int n);
    for (int i = 0; i < n && io_phase != 2'd0; i++) @(negedge clock);
    chk("reach_idle", int'(io_phase), 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    go = 1;
    chk("rst_duty", int'(io_duty), 0);
    chk("rst_phase", int'(io_phase), 0);
    chk("rst_done", int'(io_cycleDone), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_stays", int'(io_phase), 0);
    // full breath, enable raised in cycle 0
    io_stepDiv = 16'd0; io_dutyMax = 7'd3; io_enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      chk($sformatf("breath_duty_c%0d", i + 1), int'(io_duty), exp_duty[i]);
      chk($sformatf("breath_phase_c%0d", i + 1), int'(io_phase), exp_ph[i]);
      chk($sformatf("breath_done_c%0d", i + 1), int'(io_cycleDone), i == 10 ? 1 : 0);
    end
    io_enable = 1'b0;
    wait_idle(50);
    // prescaler: one step every 10 cycles
    io_stepDiv = 16'd9; io_dutyMax = 7'd5; io_enable = 1'b1;
    for (int i = 0; i < 100 && io_duty != 7'd1; i++) @(negedge clock);
    chk("presc_duty1", int'(io_duty), 1);
    t1 = cyc;
    for (int i = 0; i < 100 && io_duty != 7'd2; i++) @(negedge clock);
    chk("presc_duty2", int'(io_duty), 2);
    t2 = cyc;
    chk("presc_interval12", t2 - t1, 10);
    for (int i = 0; i < 100 && io_duty != 7'd3; i++) @(negedge clock);
    chk("presc_interval23", cyc - t2, 10);
    io_enable = 1'b0;
    wait_idle(500);
    // saturation at DUTY_LIMIT, then reset in the middle of hold
    io_stepDiv = 16'd0; io_dutyMax = 7'd127; io_enable = 1'b1;
    for (int i = 0; i < 300 && io_phase != 2'd2; i++) @(negedge clock);
    chk("sat_phase", int'(io_phase), 2);
    chk("sat_duty", int'(io_duty), 100);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_duty", int'(io_duty), 0);
    chk("midrst_phase", int'(io_phase), 0);
    chk("midrst_done", int'(io_cycleDone), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_release_rise", int'(io_phase), 1);
    // early stop at duty 40
    for (int i = 0; i < 100 && io_duty != 7'd40; i++) @(negedge clock);
    chk("early_duty40", int'(io_duty), 40);
    io_enable = 1'b0;
    @(negedge clock);
    chk("early_phase", int'(io_phase), 3);
    chk("early_duty", int'(io_duty), 40);
    for (int i = 0; i < 100 && !io_cycleDone; i++) @(negedge clock);
    chk("early_done", int'(io_cycleDone), 1);
    chk("early_idle", int'(io_phase), 0);
    repeat (5) @(negedge clock);
    chk("early_stays_idle", int'(io_phase), 0);
    // live peak change while rising
    io_stepDiv = 16'd3; io_dutyMax = 7'd50; io_enable = 1'b1;
    for (int i = 0; i < 300 && io_duty != 7'd30; i++) @(negedge clock);
    chk("live_duty30", int'(io_duty), 30);
    io_dutyMax = 7'd20;
    for (int i = 0; i < 20 && io_phase == 2'd1; i++) @(negedge clock);
    chk("live_phase", int'(io_phase), 2);
    chk("live_duty", int'(io_duty), 30);
    // enable dropped and re-raised during fall: fall completes, then rises again
    for (int i = 0; i < 50 && io_phase != 2'd3; i++) @(negedge clock);
    chk("fall_entered", int'(io_phase), 3);
    io_enable = 1'b0;
    for (int i = 0; i < 200 && io_duty != 7'd15; i++) @(negedge clock);
    io_enable = 1'b1;
    for (int i = 0; i < 200 && !io_cycleDone; i++) @(negedge clock);
    chk("refill_done", int'(io_cycleDone), 1);
    chk("refill_rise", int'(io_phase), 1);
    io_enable = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
